// File: rtl/seanetnackgenerator_bmp_pkg.sv
// seanetnackgenerator_bmp_pkg: response codes, FSM state types and line-offset helpers
// shared by the bitmap AXI slave memory.
package seanetnackgenerator_bmp_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_RD = 2'd1, R_DATA = 2'd2} r_state_t;
   function automatic int line_off(input int strb_width);
      return $clog2(strb_width);
   endfunction
   function automatic logic [1:0] resp_code(input logic err_dec, input logic err_len);
      return err_dec ? RESP_DECERR : (err_len ? RESP_SLVERR : RESP_OKAY);
   endfunction
endpackage

// File: rtl/seanetnackgenerator_bmp_axi_slave_mem_if.sv
// seanetnackgenerator_bmp_axi_slave_mem_if: AXI4 bus between the bitmap arbiter (master)
// and the on-chip bitmap memory (slave).
interface seanetnackgenerator_bmp_axi_slave_mem_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
);
   localparam int STRB_W = DATA_W / 8;
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awlock;
   logic [3:0]        awcache;
   logic [2:0]        awprot;
   logic              awvalid, awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wlast, wvalid, wready;
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid, bready;
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic              arvalid, arready;
   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast, rvalid, rready;
   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/seanetnackgenerator_bmp_sdpram.sv
// seanetnackgenerator_bmp_sdpram: simple dual-port RAM with byte write enables and a
// registered read port that returns pre-write data on a same-cycle collision.
module seanetnackgenerator_bmp_sdpram #(
   parameter int DATA_W = 512,
   parameter int ADDR_W = 10
) (
   input  logic                sys_clk,
   input  logic [DATA_W/8-1:0] we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [DATA_W-1:0]   rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always_ff @(posedge sys_clk) begin
      if (re) rdata <= mem[raddr];
      for (int i = 0; i < DATA_W / 8; i++)
         if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
   end
endmodule

// File: rtl/seanetnackgenerator_bmp_axi_slave_mem.sv
// seanetnackgenerator_bmp_axi_slave_mem: single-beat AXI4 slave over on-chip NACK bitmap RAM.
// SEANET_BMP_MEM_CLEAR_EN: sweep zeros into every line after reset before opening the bus.
module seanetnackgenerator_bmp_axi_slave_mem
   import seanetnackgenerator_bmp_pkg::*;
#(
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 512,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE_ADDR = '0
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   seanetnackgenerator_bmp_axi_slave_mem_if.slave s_axi,
   output logic [31:0] dfx_sta0,
   output logic [31:0] dfx_sta1,
   output logic [31:0] dfx_sta2,
   output logic [31:0] dfx_sta3
);
   localparam int OFF = line_off(AXI_STRB_WIDTH);
   localparam int HI  = OFF + MEM_DEPTH_LOG2;
   typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

   function automatic logic out_of_win(input logic [AXI_ADDR_WIDTH-1:0] a);
      logic [AXI_ADDR_WIDTH-1:0] d;
      d = a - MEM_BASE_ADDR;
      return |(d >> HI);
   endfunction

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;
   logic init_done, clear_busy;
   idx_t clr_idx, w_idx, r_idx, ram_waddr;
   logic [AXI_ID_WIDTH-1:0] w_id, r_id;
   logic w_err_len, w_err_dec, r_err_len, r_err_dec;
   logic [7:0] w_len, w_cnt, r_len, r_cnt;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_done, r_done;
   logic [AXI_STRB_WIDTH-1:0] ram_we;
   logic [AXI_DATA_WIDTH-1:0] ram_wdata, ram_rdata;
   logic unused;

`ifdef SEANET_BMP_MEM_CLEAR_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         clear_busy <= 1'b1;
         clr_idx    <= '0;
      end else if (clear_busy) begin
         clr_idx    <= clr_idx + 1'b1;
         clear_busy <= clr_idx != '1;
      end
`else
   assign clear_busy = 1'b0;
   assign clr_idx    = '0;
`endif

   // The bus opens one cycle after the clear sweep (or reset release) completes.
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) init_done <= 1'b0;
      else init_done <= ~clear_busy;

   assign aw_hs  = s_axi.awvalid & s_axi.awready;
   assign w_hs   = s_axi.wvalid & s_axi.wready;
   assign b_hs   = s_axi.bvalid & s_axi.bready;
   assign ar_hs  = s_axi.arvalid & s_axi.arready;
   assign r_hs   = s_axi.rvalid & s_axi.rready;
   assign w_done = w_hs & (s_axi.wlast | (w_cnt == w_len));
   assign r_done = r_hs & s_axi.rlast;

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end

   always_comb begin
      w_next = w_state;
      if (aw_hs) w_next = W_DATA;
      else if (w_done) w_next = W_RESP;
      else if (b_hs) w_next = W_IDLE;
   end

   always_comb begin
      r_next = r_state;
      if (ar_hs) r_next = R_RD;
      else if (r_state == R_RD) r_next = R_DATA;
      else if (r_done) r_next = R_IDLE;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         w_id      <= '0;
         w_idx     <= '0;
         w_len     <= '0;
         w_cnt     <= '0;
         w_err_len <= 1'b0;
         w_err_dec <= 1'b0;
      end else if (aw_hs) begin
         w_id      <= s_axi.awid;
         w_idx     <= s_axi.awaddr[HI-1:OFF];
         w_len     <= s_axi.awlen;
         w_cnt     <= '0;
         w_err_len <= s_axi.awlen != 8'd0;
         w_err_dec <= out_of_win(s_axi.awaddr);
      end else if (w_hs) w_cnt <= w_cnt + 8'd1;

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         r_id      <= '0;
         r_idx     <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_err_len <= 1'b0;
         r_err_dec <= 1'b0;
      end else if (ar_hs) begin
         r_id      <= s_axi.arid;
         r_idx     <= s_axi.araddr[HI-1:OFF];
         r_len     <= s_axi.arlen;
         r_cnt     <= '0;
         r_err_len <= s_axi.arlen != 8'd0;
         r_err_dec <= out_of_win(s_axi.araddr);
      end else if (r_hs) r_cnt <= r_cnt + 8'd1;

   assign s_axi.awready = init_done & (w_state == W_IDLE);
   assign s_axi.wready  = init_done & (w_state == W_DATA);
   assign s_axi.bvalid  = w_state == W_RESP;
   assign s_axi.bid     = w_id;
   assign s_axi.bresp   = resp_code(w_err_dec, w_err_len);
   assign s_axi.arready = init_done & (r_state == R_IDLE);
   assign s_axi.rvalid  = r_state == R_DATA;
   assign s_axi.rlast   = s_axi.rvalid & (r_cnt == r_len);
   assign s_axi.rid     = r_id;
   assign s_axi.rresp   = resp_code(r_err_dec, r_err_len);
   assign s_axi.rdata   = (s_axi.rvalid & ~(r_err_len | r_err_dec)) ? ram_rdata : '0;

   // Erroneous write beats are consumed but never reach the RAM.
   assign ram_we    = clear_busy ? '1 : (w_hs & ~(w_err_len | w_err_dec)) ? s_axi.wstrb : '0;
   assign ram_waddr = clear_busy ? clr_idx : w_idx;
   assign ram_wdata = clear_busy ? '0 : s_axi.wdata;

   seanetnackgenerator_bmp_sdpram #(.DATA_W(AXI_DATA_WIDTH), .ADDR_W(MEM_DEPTH_LOG2)) u_ram (
      .sys_clk(sys_clk),
      .we(ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .re((r_state == R_RD) & ~(r_err_len | r_err_dec)),
      .raddr(r_idx),
      .rdata(ram_rdata)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         dfx_sta0 <= '0;
         dfx_sta1 <= '0;
         dfx_sta2 <= '0;
      end else begin
         dfx_sta0 <= dfx_sta0 + 32'(aw_hs);
         dfx_sta1 <= dfx_sta1 + 32'(ar_hs);
         dfx_sta2 <= dfx_sta2 + 32'(b_hs & |s_axi.bresp) + 32'(r_done & |s_axi.rresp);
      end

   assign dfx_sta3 = {24'd0, init_done, w_state, r_state, s_axi.bvalid, s_axi.rvalid, clear_busy};

   assign unused = ^{s_axi.awsize, s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot,
                     s_axi.arsize, s_axi.arburst, s_axi.arlock, s_axi.arcache, s_axi.arprot};
endmodule

// File: doc/seanetnackgenerator_bmp_axi_slave_mem.md
Name: seanetnackgenerator_bmp_axi_slave_mem

Overview:
AXI4 slave responder backed by on-chip RAM. It holds the NACK bitmap lines that the bitmap command arbiter reads, modifies and writes back as an AXI4 master. It is used in place of DDR for small-window configurations. It serves single-beat full-line reads and writes with byte strobes and echoes transaction IDs. Malformed bursts and out-of-window addresses are answered with error responses and never touch RAM.

Parameters:
AXI_ID_WIDTH, 4, AW/AR/B/R ID width
AXI_ADDR_WIDTH, 64, address width
AXI_DATA_WIDTH, 512, line width in bits; one RAM line per beat
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, byte strobe width
MEM_DEPTH_LOG2, 10, log2 of RAM depth in lines
MEM_BASE_ADDR, 0, byte address of line 0; must be aligned to the window size

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  in  per AXI4  write address channel
s_axi_awready  out  1  write address ready
s_axi_wdata/wstrb/wlast/wvalid  in  DATA/STRB/1/1  write data channel
s_axi_wready  out  1  write data ready
s_axi_bid/bresp/bvalid  out  ID/2/1  write response
s_axi_bready  in  1  write response ready
s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  in  per AXI4  read address channel
s_axi_arready  out  1  read address ready
s_axi_rid/rdata/rresp/rlast/rvalid  out  ID/DATA/2/1/1  read data channel
s_axi_rready  in  1  read data ready
dfx_sta0..dfx_sta3  out  32 each  debug status

Behaviour:
- Line index = addr[OFF+MEM_DEPTH_LOG2-1:OFF], where OFF = log2(AXI_STRB_WIDTH). In-window means the bits of (addr - MEM_BASE_ADDR) above the index are zero.
- awsize, awburst, lock, cache and prot are ignored. Every beat targets the captured line.
- Reset (async assert, sync release): both FSMs go to IDLE; awready, wready, arready, bvalid, rvalid and rlast are 0; bresp, rresp, bid, rid and rdata are 0; the init_done flag is 0. In-flight transactions are dropped. RAM contents are untouched unless the clear feature is enabled.
- init_done rises one cycle after reset release. All readies are gated by init_done.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On the AW handshake, capture awid, the index, err_len (awlen!=0) and err_dec (out of window), then go to W_DATA.
  - W_DATA: wready=1. Each beat is accepted; it commits to RAM with wstrb byte enables only if there is no error.
  - Leave W_DATA on the beat with wlast=1, or on beat number awlen+1, whichever comes first.
  - W_RESP: bvalid=1, bid=captured ID. bresp = 2'b11 if err_dec, else 2'b10 if err_len, else 2'b00. Hold until bready, then go to W_IDLE.
- W is never accepted before AW: wready=0 in W_IDLE. AW and W presented in the same cycle: AW is taken that cycle and W the next.
- Write latency: last-W handshake at cycle M gives bvalid at M+1.
- Read FSM R_IDLE -> R_RD -> R_DATA:
  - R_IDLE: arready=1. On the AR handshake, capture arid, index, arlen and error flags, then go to R_RD.
  - R_RD: issue the RAM read (1-cycle latency), then go to R_DATA.
  - R_DATA: rvalid=1, rid=captured ID. rdata = RAM line, or zero on error. rresp uses the same encoding as bresp.
  - On arlen>0, return arlen+1 beats, all zero data with SLVERR. The beat counter is 8 bits. rlast=1 on the final beat only.
  - rvalid, rdata and rlast are held stable until rready. After the final beat go to R_IDLE.
- Read latency: AR handshake at cycle N gives rvalid at N+2.
- Independent read and write ports. A RAM read and a write to the same index in the same cycle return pre-write (old) data.
- A write is visible to any AR accepted after its B handshake.
- DFX counters wrap at 2^32:
  - dfx_sta0 = accepted write transactions.
  - dfx_sta1 = accepted read transactions.
  - dfx_sta2 = error responses issued.
  - dfx_sta3 = {24'd0, init_done, w_state[1:0], r_state[1:0], bvalid, rvalid, clear_busy}.

Optional Feature:
SEANET_BMP_MEM_CLEAR_EN
- Defined: after reset release, a sweep writes zero to every line, one line per cycle (2^MEM_DEPTH_LOG2 cycles). clear_busy=1 and init_done=0 during the sweep, so all readies stay 0. init_done rises the cycle after the last line is written. Reset during the sweep restarts it.
- Undefined: no sweep; clear_busy is tied to 0 and RAM contents are undefined after power-up.

Decomposition:
- Package seanetnackgenerator_bmp_pkg: RESP_OKAY/RESP_SLVERR/RESP_DECERR, the w_state and r_state enums, and the line-offset localparam function.
- One sub-module, seanetnackgenerator_bmp_sdpram: simple dual-port RAM with byte write enables, one write port, one read port, 1-cycle registered read, read-first collision behaviour.

Test Plan:
- Post-init, AW 0x140 id=3 with W of all 0xA5 and full strb → bvalid 1 cycle after W, bid=3, bresp=00. Then AR 0x140 id=5 → rvalid 2 cycles after AR, rdata all 0xA5, rid=5, rlast=1.
- Line 0x140 pre-set to zero, write with wstrb=64'h1 and data all 0xFF → readback byte0=0xFF, all other bytes 0x00.
- awlen=3: 4 W beats accepted, bresp=10, RAM unchanged. arlen=1: 2 beats of zero data, rresp=10, rlast only on beat 2.
- MEM_DEPTH_LOG2=10, base 0, AW/AR to 0x10000 → bresp=11 and rresp=11 with rdata 0. dfx_sta2 increments by 2.
- Backpressure: bready low 5 cycles → bvalid held, awready 0. rready low 5 cycles → rdata and rid stable. Bitmap RMW sequence (read, set bit 7, write, read, clear bit 7, write) → final line unchanged.
- With SEANET_BMP_MEM_CLEAR_EN, depth 1024, memory pre-filled: assert sys_rst_n low mid-R_DATA → rvalid drops immediately. After release, readies stay 0 for 1024+1 cycles, then any line reads zero.
